// File: rtl/debounce_multi.sv
// rtl/debounce_multi.sv - multi-channel debouncer with edge pulses and sticky event flags
module debounce_multi #(
   parameter int CHANNELS      = 4,
   parameter int STABLE_CYCLES = 4000000,
   parameter int CNT_W         = 22,
   parameter int SYNC_STAGES   = 2
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [CHANNELS-1:0] in,
   input  logic [1:0]          mode,
   input  logic [CHANNELS-1:0] clr,
   output logic [CHANNELS-1:0] level,
   output logic [CHANNELS-1:0] pulse,
   output logic [CHANNELS-1:0] evt
);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [SYNC_STAGES-1:0][CHANNELS-1:0] sync_q, sync_d;
   logic [CHANNELS-1:0][CNT_W-1:0]       cnt_q, cnt_d;
   logic [CHANNELS-1:0]                  level_q, level_d;
   logic [CHANNELS-1:0]                  pulse_q, pulse_d;
   logic [CHANNELS-1:0]                  evt_q, evt_d;
   logic [CHANNELS-1:0]                  s;

   always_comb begin
      sync_d    = sync_q;
      sync_d[0] = in;
      for (int k = 1; k < SYNC_STAGES; k++) begin
         sync_d[k] = sync_q[k-1];
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   // A channel's count only advances while the synchronised input disagrees with the accepted level.
   always_comb begin
      level_d = level_q;
      pulse_d = '0;
      cnt_d   = cnt_q;
      evt_d   = evt_q & ~clr;
      for (int i = 0; i < CHANNELS; i++) begin
         if (s[i] == level_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] < CNT_LAST) begin
            cnt_d[i] = cnt_q[i] + CNT_ONE;
         end else begin
            cnt_d[i]   = '0;
            level_d[i] = s[i];
            pulse_d[i] = s[i] ? mode[0] : mode[1];
         end
      end
      evt_d = evt_d | pulse_d;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sync_q  <= '0;
         cnt_q   <= '0;
         level_q <= '0;
         pulse_q <= '0;
         evt_q   <= '0;
      end else begin
         sync_q  <= sync_d;
         cnt_q   <= cnt_d;
         level_q <= level_d;
         pulse_q <= pulse_d;
         evt_q   <= evt_d;
      end
   end

   assign level = level_q;
   assign pulse = pulse_q;
   assign evt   = evt_q;
endmodule

// File: tb/tb_debounce_multi.sv
// tb/tb_debounce_multi.sv - self-checking bench for debounce_multi
module tb_debounce_multi;
   localparam int CH = 4;
   localparam int SC = 4;
   localparam int CW = 3;
   localparam int SS = 2;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [CH-1:0] din = '0;
   logic [1:0]    mode = 2'b00;
   logic [CH-1:0] clr = '0;
   logic [CH-1:0] level, pulse, evt;

   int total = 0;
   int bad   = 0;

   debounce_multi #(
      .CHANNELS(CH), .STABLE_CYCLES(SC), .CNT_W(CW), .SYNC_STAGES(SS)
   ) dut (
      .clk(clk), .rst(rst), .in(din), .mode(mode), .clr(clr),
      .level(level), .pulse(pulse), .evt(evt)
   );

   always #5 clk = ~clk;

   // Reference: input delayed SS edges, accepted once the last SC samples all differ from level.
   logic [CH-1:0] m_level, m_pulse, m_evt;
   logic [CH-1:0] pipe [SS];
   logic [CH-1:0] win  [SC];

   typedef struct {
      logic [CH-1:0] din;
      logic [1:0]    mode;
      logic [CH-1:0] clr;
      logic [CH-1:0] lvl;
      logic [CH-1:0] pls;
      logic [CH-1:0] ev;
   } vec_t;
   vec_t tbl [14];

   task automatic model_reset();
      m_level = '0;
      m_pulse = '0;
      m_evt   = '0;
      foreach (pipe[k]) pipe[k] = '0;
      foreach (win[k]) win[k] = '0;
   endtask

   task automatic model_edge();
      logic [CH-1:0] s;
      logic          all_diff;
      s = pipe[SS-1];
      for (int k = SC-1; k > 0; k--) win[k] = win[k-1];
      win[0] = s;
      for (int c = 0; c < CH; c++) begin
         all_diff = 1'b1;
         for (int k = 0; k < SC; k++) if (win[k][c] == m_level[c]) all_diff = 1'b0;
         m_pulse[c] = 1'b0;
         if (all_diff) begin
            m_level[c] = s[c];
            m_pulse[c] = s[c] ? mode[0] : mode[1];
         end
      end
      m_evt = m_pulse | (m_evt & ~clr);
      for (int k = SS-1; k > 0; k--) pipe[k] = pipe[k-1];
      pipe[0] = din;
   endtask

   task automatic check(input string name, input logic [CH-1:0] got, input logic [CH-1:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%b exp=%b at %0t", name, got, exp, $time);
      end
   endtask

   task automatic step();
      @(posedge clk);
      if (!rst) model_reset();
      else model_edge();
      #1;
      check("model_level", level, m_level);
      check("model_pulse", pulse, m_pulse);
      check("model_evt", evt, m_evt);
   endtask

   initial begin
      for (int i = 0; i < 14; i++) begin
         tbl[i].mode = 2'b01;
         tbl[i].clr  = '0;
         if (i < 7) begin
            tbl[i].din = 4'b0001;
            tbl[i].lvl = (i >= 5) ? 4'b0001 : 4'b0000;
            tbl[i].pls = (i == 5) ? 4'b0001 : 4'b0000;
            tbl[i].ev  = (i >= 5) ? 4'b0001 : 4'b0000;
         end else begin
            tbl[i].din = 4'b0000;
            tbl[i].lvl = (i - 7 >= 5) ? 4'b0000 : 4'b0001;
            tbl[i].pls = 4'b0000;
            tbl[i].ev  = 4'b0001;
         end
      end

      model_reset();
      #1 rst = 1'b0;
      #1;
      check("reset_level", level, '0);
      check("reset_pulse", pulse, '0);
      check("reset_evt", evt, '0);
      step();
      step();
      rst = 1'b1;

      // clean press and release, rising only
      for (int i = 0; i < 14; i++) begin
         din  = tbl[i].din;
         mode = tbl[i].mode;
         clr  = tbl[i].clr;
         step();
         check("vec_level", level, tbl[i].lvl);
         check("vec_pulse", pulse, tbl[i].pls);
         check("vec_evt", evt, tbl[i].ev);
      end

      // sticky flag: clear alone, then set and clear on the same edge
      clr = 4'b0001;
      step();
      check("clr_alone_first", evt, 4'b0000);
      clr = 4'b0000;
      din = 4'b0001;
      repeat (5) step();
      clr = 4'b0001;
      step();
      check("set_wins_pulse", pulse, 4'b0001);
      check("set_wins_evt", evt, 4'b0001);
      clr = 4'b0000;
      step();
      check("evt_held", evt, 4'b0001);
      clr = 4'b0001;
      step();
      check("clr_alone", evt, 4'b0000);
      clr = 4'b0000;
      din = 4'b0000;
      repeat (7) step();

      // bounce on channel 1, both edges
      mode = 2'b11;
      din  = 4'b0010;
      repeat (3) step();
      din = 4'b0000;
      step();
      din = 4'b0010;
      for (int i = 1; i <= 6; i++) begin
         step();
         if (i < 6) check("bounce_hold", level, 4'b0000);
      end
      check("bounce_rise_level", level, 4'b0010);
      check("bounce_rise_pulse", pulse, 4'b0010);
      din = 4'b0000;
      repeat (6) step();
      check("bounce_fall_level", level, 4'b0000);
      check("bounce_fall_pulse", pulse, 4'b0010);
      step();
      check("bounce_one_cycle", pulse, 4'b0000);

      // independent channels, falling only
      mode = 2'b10;
      din  = 4'b1100;
      repeat (8) step();
      check("indep_high_level", level, 4'b1100);
      check("indep_no_rise", pulse, 4'b0000);
      din = 4'b1000;
      step();
      din = 4'b0000;
      repeat (4) step();
      step();
      check("indep_ch2_level", level, 4'b1000);
      check("indep_ch2_pulse", pulse, 4'b0100);
      step();
      check("indep_ch3_level", level, 4'b0000);
      check("indep_ch3_pulse", pulse, 4'b1000);

      clr = 4'b1111;
      step();
      clr = 4'b0000;
      check("clr_all", evt, 4'b0000);

      // mode 00: level debounces, no pulse or flag
      mode = 2'b00;
      din  = 4'b0001;
      repeat (6) step();
      check("m00_level", level, 4'b0001);
      check("m00_pulse", pulse, 4'b0000);
      check("m00_evt", evt, 4'b0000);
      din = 4'b0000;
      repeat (6) step();
      check("m00_rel_level", level, 4'b0000);
      check("m00_rel_evt", evt, 4'b0000);

      // reset in the middle of a count
      mode = 2'b11;
      din  = 4'b0010;
      repeat (6) step();
      check("rst_pre_level", level, 4'b0010);
      mode = 2'b01;
      din  = 4'b0011;
      repeat (4) step();
      #2 rst = 1'b0;
      model_reset();
      #1;
      check("rst_async_level", level, 4'b0000);
      check("rst_async_pulse", pulse, 4'b0000);
      check("rst_async_evt", evt, 4'b0000);
      step();
      rst = 1'b1;
      for (int i = 1; i <= 6; i++) begin
         step();
         if (i < 6) check("rst_recount", level, 4'b0000);
      end
      check("rst_after_level", level, 4'b0011);
      check("rst_after_pulse", pulse, 4'b0011);

      // random traffic against the reference
      for (int n = 0; n < 600; n++) begin
         for (int c = 0; c < CH; c++) begin
            if ($urandom_range(0, 9) == 0) din[c] = ~din[c];
            clr[c] = ($urandom_range(0, 7) == 0);
         end
         if ($urandom_range(0, 31) == 0) mode = 2'($urandom_range(0, 3));
         step();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
